// File: rtl/drum_mul_pipe_if.sv
// Operand/result handshake bundle for drum_mul_pipe.
// The slave side is the multiplier; the master side is the surrounding tile.
interface drum_mul_pipe_if #(
    parameter int unsigned N = 4,
    parameter int unsigned M = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [M-1:0]     in_b;
    logic             in_exact;
    logic             out_valid;
    logic             out_ready;
    logic [N+M-1:0]   out_r;
    logic             out_exact;

    modport master (
        output in_valid, in_a, in_b, in_exact, out_ready,
        input  in_ready, out_valid, out_r, out_exact
    );

    modport slave (
        input  in_valid, in_a, in_b, in_exact, out_ready,
        output in_ready, out_valid, out_r, out_exact
    );
endinterface

// File: rtl/drum_mul_pipe.sv
// Three-stage DRUM approximate multiplier: leading-one truncate, multiply, shift back.
// A single advance signal moves the whole pipe; a full output stage stalls everything.
module drum_mul_pipe #(
    parameter int unsigned K = 3,
    parameter int unsigned N = 4,
    parameter int unsigned M = 4
) (
    input logic              clk,
    input logic              rst,
    drum_mul_pipe_if.slave   bus
);
    localparam int unsigned W  = (N > M) ? N : M;
    localparam int unsigned P  = N + M;
    localparam int unsigned SW = $clog2(P + 1);

    // Keep the K bits starting at the leading one; force the LSB to 1 to unbias the truncation.
    function automatic void lod(input logic [W-1:0] x, output logic [K-1:0] t,
                                output logic [SW-1:0] s);
        int          p;
        logic [W-1:0] xs;
        p  = 0;
        xs = '0;
        for (int i = 0; i < int'(W); i++) begin
            if (x[i]) p = i;
        end
        if ((x >> K) == '0) begin
            t = x[K-1:0];
            s = '0;
        end else begin
            xs = x >> (p - int'(K) + 1);
            t  = xs[K-1:0] | K'(1);
            s  = SW'(p - int'(K) + 1);
        end
    endfunction

    logic          adv;

    logic          v1_q;
    logic [K-1:0]  ta_q, tb_q, ta_d, tb_d;
    logic [SW-1:0] sa_q, sb_q, sa_d, sb_d;
    logic [N-1:0]  a_q;
    logic [M-1:0]  b_q;
    logic          ex1_q;

    logic          v2_q;
    logic [P-1:0]  q_q, q_d;
    logic [SW-1:0] sh_q, sh_d;
    logic          ex2_q;

    logic          out_valid_q;
    logic [P-1:0]  out_r_q, out_r_d;
    logic          out_exact_q;

    assign adv          = !out_valid_q | bus.out_ready;
    assign bus.in_ready = adv & !rst;

    assign bus.out_valid = out_valid_q;
    assign bus.out_r     = out_r_q;
    assign bus.out_exact = out_exact_q;

    always_comb begin
        ta_d = '0;
        tb_d = '0;
        sa_d = '0;
        sb_d = '0;
        lod(W'(bus.in_a), ta_d, sa_d);
        lod(W'(bus.in_b), tb_d, sb_d);
    end

    always_comb begin
        q_d  = '0;
        sh_d = '0;
        if (ex1_q) begin
            q_d = P'(a_q) * P'(b_q);
        end else begin
            q_d  = P'(ta_q) * P'(tb_q);
            sh_d = sa_q + sb_q;
        end
    end

    // 2K + (N-K) + (M-K) = N+M, so the shift never loses a set bit.
    assign out_r_d = q_q << sh_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            ta_q        <= '0;
            tb_q        <= '0;
            sa_q        <= '0;
            sb_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ex1_q       <= 1'b0;
            v2_q        <= 1'b0;
            q_q         <= '0;
            sh_q        <= '0;
            ex2_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_exact_q <= 1'b0;
        end else if (adv) begin
            v1_q        <= bus.in_valid;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            if (bus.in_valid) begin
                ta_q  <= ta_d;
                tb_q  <= tb_d;
                sa_q  <= sa_d;
                sb_q  <= sb_d;
                a_q   <= bus.in_a;
                b_q   <= bus.in_b;
                ex1_q <= bus.in_exact;
            end
            if (v1_q) begin
                q_q   <= q_d;
                sh_q  <= sh_d;
                ex2_q <= ex1_q;
            end
            if (v2_q) begin
                out_r_q     <= out_r_d;
                out_exact_q <= ex2_q;
            end
        end
    end
endmodule

// File: tb/tb_drum_mul_pipe.sv
// Self-checking bench for drum_mul_pipe: directed vector table, streaming, random
// backpressure against a reference model, and reset with beats in flight.
module tb_drum_mul_pipe;
    localparam int unsigned K = 3;
    localparam int unsigned N = 4;
    localparam int unsigned M = 4;
    localparam int unsigned P = N + M;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    drum_mul_pipe_if #(.N(N), .M(M)) bus ();

    drum_mul_pipe #(.K(K), .N(N), .M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: shift right until the operand fits in K bits, then force the LSB if shifted.
    function automatic void drum_term(input int unsigned x, output int unsigned t,
                                      output int unsigned s);
        s = 0;
        while ((x >> s) >= (32'd1 << K)) s++;
        t = x >> s;
        if (s != 0) t = t | 32'd1;
    endfunction

    function automatic int unsigned ref_mul(input int unsigned a, input int unsigned b,
                                            input bit ex);
        int unsigned ta, sa, tb, sb, r;
        if (ex) return a * b;
        drum_term(a, ta, sa);
        drum_term(b, tb, sb);
        r = (ta * tb) << (sa + sb);
        return r & ((32'd1 << P) - 1);
    endfunction

    typedef struct {
        int unsigned a;
        int unsigned b;
        bit          ex;
        int unsigned r;
    } vec_t;

    // Push beats for n_beats, optionally with random valid/ready, and score every result.
    task automatic stream(input int n_beats, input bit rnd, input string tag);
        int unsigned exp_r_q[$];
        bit          exp_ex_q[$];
        int          sent = 0, got = 0, cyc = 0, first = -1, last = -1;
        bit          held = 1'b0;
        logic [P-1:0] held_r = '0;
        int unsigned er;
        bit          ee;
        while ((sent < n_beats || exp_r_q.size() > 0) && cyc < n_beats * 8 + 20) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_valid  = (sent < n_beats) && (!rnd || ($urandom_range(0, 3) != 0));
            bus.in_a      = N'($urandom_range(0, (1 << N) - 1));
            bus.in_b      = M'($urandom_range(0, (1 << M) - 1));
            bus.in_exact  = 1'($urandom_range(0, 1));
            #1;
            if (held) begin
                check({tag, " held_valid"}, 32'(bus.out_valid), 32'd1);
                check({tag, " held_r"}, 32'(bus.out_r), 32'(held_r));
            end
            if (bus.out_valid)
                check({tag, " in_ready_eq_out_ready"}, 32'(bus.in_ready), 32'(bus.out_ready));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_r_q.size() == 0) begin
                    check({tag, " unexpected_result"}, 32'd1, 32'd0);
                end else begin
                    er = exp_r_q.pop_front();
                    ee = exp_ex_q.pop_front();
                    check({tag, " r"}, 32'(bus.out_r), er);
                    check({tag, " exact"}, 32'(bus.out_exact), 32'(ee));
                end
                got++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            held   = bus.out_valid && !bus.out_ready;
            held_r = bus.out_r;
            if (bus.in_valid && bus.in_ready) begin
                exp_r_q.push_back(ref_mul(32'(bus.in_a), 32'(bus.in_b), bus.in_exact));
                exp_ex_q.push_back(bus.in_exact);
                sent++;
            end
            tick();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check({tag, " beats_sent"}, 32'(sent), 32'(n_beats));
        check({tag, " results_got"}, 32'(got), 32'(n_beats));
        if (!rnd) check({tag, " consecutive"}, 32'(last - first), 32'(n_beats - 1));
    endtask

    task automatic push_and_check(input vec_t v, input string tag);
        bus.in_valid  = 1'b1;
        bus.in_a      = N'(v.a);
        bus.in_b      = M'(v.b);
        bus.in_exact  = v.ex;
        bus.out_ready = 1'b1;
        #1;
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check({tag, " lat1_valid"}, 32'(bus.out_valid), 32'd0);
        tick();
        check({tag, " lat2_valid"}, 32'(bus.out_valid), 32'd0);
        tick();
        check({tag, " valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, " r"}, 32'(bus.out_r), v.r);
        check({tag, " exact"}, 32'(bus.out_exact), 32'(v.ex));
    endtask

    initial begin
        vec_t vecs[11];
        vecs[0]  = '{a: 13, b: 11, ex: 1'b0, r: 140};
        vecs[1]  = '{a: 13, b: 11, ex: 1'b1, r: 143};
        vecs[2]  = '{a: 3,  b: 2,  ex: 1'b0, r: 6};
        vecs[3]  = '{a: 0,  b: 15, ex: 1'b0, r: 0};
        vecs[4]  = '{a: 15, b: 15, ex: 1'b0, r: 196};
        vecs[5]  = '{a: 15, b: 15, ex: 1'b1, r: 225};
        vecs[6]  = '{a: 0,  b: 0,  ex: 1'b1, r: 0};
        vecs[7]  = '{a: 7,  b: 7,  ex: 1'b0, r: 49};
        vecs[8]  = '{a: 8,  b: 8,  ex: 1'b0, r: 100};
        vecs[9]  = '{a: 15, b: 1,  ex: 1'b0, r: 14};
        vecs[10] = '{a: 12, b: 4,  ex: 1'b1, r: 48};

        // Reset held with a valid beat offered: nothing is accepted, nothing emerges.
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = 4'd13;
        bus.in_b      = 4'd11;
        bus.in_exact  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset in_ready", 32'(bus.in_ready), 32'd0);
            check("reset out_valid", 32'(bus.out_valid), 32'd0);
            check("reset out_r", 32'(bus.out_r), 32'd0);
            check("reset out_exact", 32'(bus.out_exact), 32'd0);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_reset out_valid", 32'(bus.out_valid), 32'd0);
        end

        for (int i = 0; i < 11; i++) push_and_check(vecs[i], $sformatf("vec%0d", i));
        tick();

        stream(16, 1'b0, "stream");
        tick();
        stream(1000, 1'b1, "backpressure");
        tick();

        // Three beats in flight, then reset: all discarded.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = N'(i + 9);
            bus.in_b     = 4'd15;
            bus.in_exact = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        tick();
        check("flight_reset out_valid", 32'(bus.out_valid), 32'd0);
        check("flight_reset in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("flight_drain out_valid", 32'(bus.out_valid), 32'd0);
        end
        push_and_check(vecs[0], "after_reset");
        tick();
        check("after_reset single", 32'(bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
